// File: rtl/free_list.sv
// Physical-register free list: in-order tag allocation for dispatch, stale-tag
// return at retirement, and single-cycle rollback of speculative allocations on squash.
module free_list #(
  parameter int N_WAY = 2,
  parameter int N_PR  = 64,
  parameter int N_AR  = 32,
  parameter int N_FL  = N_PR - N_AR,
  parameter int TB    = $clog2(N_PR)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_WAY-1:0]        alloc_req,
  output logic [N_WAY-1:0]        alloc_gnt,
  output logic [N_WAY*TB-1:0]     alloc_tag,
  input  logic [N_WAY-1:0]        free_valid,
  input  logic [N_WAY*TB-1:0]     free_tag,
  input  logic [$clog2(N_WAY):0]  retire_cnt,
  input  logic                    squash,
  output logic [$clog2(N_FL):0]   num_free,
  output logic [$clog2(N_WAY):0]  avail,
  output logic                    overflow_err
);

  localparam int PW = $clog2(N_FL) + 1;
  localparam int IW = PW - 1;
  localparam int CW = $clog2(N_WAY) + 1;
  localparam logic [PW-1:0] FL_P  = PW'(N_FL);
  localparam logic [PW-1:0] WAY_P = PW'(N_WAY);

  logic [TB-1:0] mem_q [N_FL];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] arch_head_q, arch_head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic          err_q, err_d;

  logic [PW-1:0] alloc_cnt, rd_ptr;
  logic          blocked;
  logic [PW-1:0] free_cnt, wr_ptr;
  logic [N_WAY-1:0] free_we;
  logic [IW-1:0] free_idx [N_WAY];
  logic [PW-1:0] spec_cnt, retire_ext, occ_d;
  logic          arch_err, free_err;

  // Pointers carry a wrap MSB, so plain modular subtraction gives occupancy.
  assign num_free     = tail_q - head_q;
  assign avail        = (num_free < WAY_P) ? num_free[CW-1:0] : CW'(N_WAY);
  assign overflow_err = err_q;

  // In-order grant: once a requesting slot misses, every younger slot misses too.
  always_comb begin
    alloc_gnt = '0;
    alloc_tag = '0;
    alloc_cnt = '0;
    rd_ptr    = '0;
    blocked   = 1'b0;
    for (int i = 0; i < N_WAY; i++) begin
      rd_ptr = head_q + alloc_cnt;
      alloc_tag[i*TB +: TB] = mem_q[rd_ptr[IW-1:0]];
      if (alloc_req[i]) begin
        if (!blocked && !squash && (alloc_cnt < num_free)) begin
          alloc_gnt[i] = 1'b1;
          alloc_cnt    = alloc_cnt + PW'(1);
        end else begin
          blocked = 1'b1;
        end
      end
    end
  end

  // Tag 0 is the hard-wired zero register and is never returned to the pool.
  always_comb begin
    free_cnt = '0;
    wr_ptr   = '0;
    free_we  = '0;
    for (int i = 0; i < N_WAY; i++) begin
      wr_ptr      = tail_q + free_cnt;
      free_idx[i] = wr_ptr[IW-1:0];
      free_we[i]  = free_valid[i] && (free_tag[i*TB +: TB] != '0);
      if (free_we[i]) begin
        free_cnt = free_cnt + PW'(1);
      end
    end
  end

  // Squash rewinds the speculative head onto the freshly committed head.
  always_comb begin
    spec_cnt    = head_q - arch_head_q;
    retire_ext  = PW'(retire_cnt);
    arch_err    = retire_ext > spec_cnt;
    arch_head_d = arch_err ? arch_head_q : arch_head_q + retire_ext;
    head_d      = squash ? arch_head_d : head_q + alloc_cnt;
    occ_d       = tail_q + free_cnt - head_d;
    free_err    = occ_d > FL_P;
    tail_d      = free_err ? tail_q : tail_q + free_cnt;
    err_d       = err_q | arch_err | free_err;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q      <= '0;
      arch_head_q <= '0;
      tail_q      <= FL_P;
      err_q       <= 1'b0;
      for (int i = 0; i < N_FL; i++) begin
        mem_q[i] <= TB'(N_AR + i);
      end
    end else begin
      head_q      <= head_d;
      arch_head_q <= arch_head_d;
      tail_q      <= tail_d;
      err_q       <= err_d;
      for (int i = 0; i < N_WAY; i++) begin
        if (free_we[i] && !free_err) begin
          mem_q[free_idx[i]] <= free_tag[i*TB +: TB];
        end
      end
    end
  end

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: directed scenarios plus a random phase,
// checked against a queue model of the free pool and in-flight allocations.
module tb_free_list;

  localparam int N_WAY = 2;
  localparam int N_PR  = 64;
  localparam int N_AR  = 32;
  localparam int N_FL  = 32;
  localparam int TB    = 6;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [N_WAY-1:0]     alloc_req;
  logic [N_WAY-1:0]     alloc_gnt;
  logic [N_WAY*TB-1:0]  alloc_tag;
  logic [N_WAY-1:0]     free_valid;
  logic [N_WAY*TB-1:0]  free_tag;
  logic [1:0]           retire_cnt;
  logic                 squash;
  logic [5:0]           num_free;
  logic [1:0]           avail;
  logic                 overflow_err;

  always #5 clock = ~clock;

  free_list #(.N_WAY(N_WAY), .N_PR(N_PR), .N_AR(N_AR)) dut (
    .clock(clock), .reset(reset),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
    .free_valid(free_valid), .free_tag(free_tag), .retire_cnt(retire_cnt),
    .squash(squash), .num_free(num_free), .avail(avail),
    .overflow_err(overflow_err)
  );

  // Model: pool holds allocatable tags in order; inflight holds uncommitted allocations.
  int pool[$];
  int inflight[$];
  bit mErr;
  logic [1:0] expGnt;
  int expTag[2];
  int errors = 0;
  int checks = 0;

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic checkOutput(input logic [1:0] req, input logic sq);
    int k = 0;
    bit blk = 0;
    expGnt = '0;
    for (int i = 0; i < N_WAY; i++) begin
      if (req[i]) begin
        if (!blk && !sq && k < pool.size()) begin
          expGnt[i] = 1'b1;
          expTag[i] = pool[k];
          k++;
        end else begin
          blk = 1;
        end
      end
    end
    checkValue("num_free", num_free, pool.size());
    checkValue("avail", avail, (pool.size() < N_WAY) ? pool.size() : N_WAY);
    checkValue("overflow_err", overflow_err, mErr);
    checkValue("alloc_gnt", alloc_gnt, expGnt);
    for (int i = 0; i < N_WAY; i++) begin
      if (expGnt[i]) checkValue($sformatf("alloc_tag%0d", i), alloc_tag[i*TB +: TB], expTag[i]);
    end
  endtask

  task automatic modelStep(input logic [1:0] fv, input int t0, input int t1, input int rc, input logic sq);
    bit archOk = (rc <= inflight.size());
    int fr[$];
    if (!archOk) mErr = 1;
    for (int i = 0; i < N_WAY; i++) begin
      if (expGnt[i]) inflight.push_back(pool.pop_front());
    end
    if (archOk) repeat (rc) void'(inflight.pop_front());
    if (sq) begin
      while (inflight.size() > 0) pool.push_front(inflight.pop_back());
    end
    if (fv[0] && t0 != 0) fr.push_back(t0);
    if (fv[1] && t1 != 0) fr.push_back(t1);
    if (pool.size() + fr.size() > N_FL) mErr = 1;
    else foreach (fr[j]) pool.push_back(fr[j]);
  endtask

  task automatic applyStimulus(input logic [1:0] req, input logic [1:0] fv, input int t0,
                               input int t1, input int rc, input logic sq);
    alloc_req  = req;
    free_valid = fv;
    free_tag   = {TB'(t1), TB'(t0)};
    retire_cnt = 2'(rc);
    squash     = sq;
    #4;
    checkOutput(req, sq);
    modelStep(fv, t0, t1, rc, sq);
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    reset      = 1'b1;
    alloc_req  = '0;
    free_valid = '0;
    free_tag   = '0;
    retire_cnt = '0;
    squash     = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    pool.delete();
    inflight.delete();
    for (int i = 0; i < N_FL; i++) pool.push_back(N_AR + i);
    mErr = 0;
  endtask

  // Frees are limited to tags the core could really own, so the model stays legal.
  task automatic legalCycle(input logic [1:0] req, input int wantRc, input int wantFree,
                            input logic sq, input bit zeroTag);
    int rc = (wantRc < inflight.size()) ? wantRc : inflight.size();
    int legal = N_FL - pool.size() - inflight.size() + rc;
    int n;
    logic [1:0] fv = '0;
    int t[2] = '{0, 0};
    n = (wantFree > legal) ? legal : wantFree;
    if (n < 0) n = 0;
    for (int i = 0; i < n; i++) begin
      fv[i] = 1'b1;
      t[i]  = int'($urandom_range(1, 63));
    end
    if (zeroTag && n < 2) fv[n] = 1'b1;
    applyStimulus(req, fv, t[0], t[1], rc, sq);
  endtask

  initial begin
    doReset();
    checkValue("rst_num_free", num_free, 32);
    checkValue("rst_avail", avail, 2);
    checkValue("rst_err", overflow_err, 0);

    // Drain the whole pool two tags at a time, then confirm it is empty.
    for (int c = 0; c < 16; c++) begin
      alloc_req = 2'b11;
      #1;
      checkValue("drain_tag0", alloc_tag[TB-1:0], 32 + 2 * c);
      applyStimulus(2'b11, 2'b00, 0, 0, 0, 1'b0);
    end
    alloc_req = 2'b11;
    #1;
    checkValue("empty_gnt", alloc_gnt, 0);
    checkValue("empty_avail", avail, 0);
    applyStimulus(2'b11, 2'b00, 0, 0, 0, 1'b0);

    // One free entry against a two-slot request.
    doReset();
    for (int c = 0; c < 15; c++) applyStimulus(2'b11, 2'b00, 0, 0, 0, 1'b0);
    applyStimulus(2'b01, 2'b00, 0, 0, 0, 1'b0);
    alloc_req = 2'b11;
    #1;
    checkValue("partial_gnt", alloc_gnt, 2'b01);
    applyStimulus(2'b11, 2'b00, 0, 0, 0, 1'b0);
    checkValue("partial_avail", avail, 0);

    // Request hole: slot 1 alone takes the head tag.
    doReset();
    alloc_req = 2'b10;
    #1;
    checkValue("hole_tag1", alloc_tag[2*TB-1:TB], 32);
    applyStimulus(2'b10, 2'b00, 0, 0, 0, 1'b0);

    // Squash rollback with a retire and a free landing in the cycle before.
    doReset();
    applyStimulus(2'b11, 2'b00, 0, 0, 0, 1'b0);
    applyStimulus(2'b11, 2'b00, 0, 0, 0, 1'b0);
    applyStimulus(2'b00, 2'b01, 5, 0, 1, 1'b0);
    applyStimulus(2'b11, 2'b00, 0, 0, 0, 1'b1);
    checkValue("sq_num_free", num_free, 32);
    alloc_req = 2'b01;
    #1;
    checkValue("sq_tag0", alloc_tag[TB-1:0], 33);
    applyStimulus(2'b01, 2'b00, 0, 0, 0, 1'b0);

    // Free ordering behind the last remaining tag.
    doReset();
    for (int c = 0; c < 15; c++) applyStimulus(2'b11, 2'b00, 0, 0, 0, 1'b0);
    applyStimulus(2'b01, 2'b00, 0, 0, 0, 1'b0);
    applyStimulus(2'b00, 2'b11, 7, 9, 0, 1'b0);
    checkValue("wrap_num_free", num_free, 3);
    alloc_req = 2'b01;
    #1;
    checkValue("wrap_first", alloc_tag[TB-1:0], 63);
    applyStimulus(2'b01, 2'b00, 0, 0, 0, 1'b0);
    #1;
    checkValue("wrap_second", alloc_tag[TB-1:0], 7);
    applyStimulus(2'b01, 2'b00, 0, 0, 0, 1'b0);
    #1;
    checkValue("wrap_third", alloc_tag[TB-1:0], 9);
    applyStimulus(2'b01, 2'b00, 0, 0, 0, 1'b0);

    // Steady two-wide flow with an odd offset so pointers cross index 31->0 mid-cycle.
    doReset();
    applyStimulus(2'b01, 2'b00, 0, 0, 0, 1'b0);
    legalCycle(2'b11, 1, 1, 1'b0, 0);
    for (int c = 0; c < 60; c++) legalCycle(2'b11, 2, 2, 1'b0, 0);

    // Overflow on free is sticky and the offending free is dropped.
    doReset();
    applyStimulus(2'b00, 2'b11, 5, 6, 0, 1'b0);
    checkValue("err_set", overflow_err, 1);
    checkValue("err_num_free", num_free, 32);
    applyStimulus(2'b00, 2'b00, 0, 0, 0, 1'b0);
    checkValue("err_sticky", overflow_err, 1);
    doReset();
    checkValue("err_cleared", overflow_err, 0);

    // Committing more than was allocated is also an error.
    applyStimulus(2'b00, 2'b00, 0, 0, 1, 1'b0);
    checkValue("arch_err", overflow_err, 1);

    // Random traffic with occasional squashes and zero-tag frees, then reset mid-flight.
    doReset();
    for (int c = 0; c < 400; c++) begin
      legalCycle(2'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0));
    end
    doReset();
    checkValue("midrst_num_free", num_free, 32);
    checkValue("midrst_err", overflow_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
